uart_receiver: RTL and testbench

//  Receive end of the team's UART link: deserialises 8N1 frames on i_rx into parallel bytes for
//  the board side (LEDs / downstream logic). Pairs with uart_xmitter at the same CLKS_PER_BIT.
//  Per received byte: one-cycle data-valid strobe; malformed frames are flagged, not delivered.

---
 rtl/uart_receiver_if.sv | 22 ++
 rtl/uart_receiver.sv | 148 ++++++++++++++
 tb/tb_uart_receiver.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Serial-in / parallel-out bundle between the UART receiver and its consumer.
// The master modport is the receiver side; the slave modport is the board-side consumer.
interface uart_receiver_if #(
  parameter int WORD_SIZE = 8
);
  logic                 i_rx;
  logic [WORD_SIZE-1:0] o_data_out;
  logic                 o_data_DV;
  logic                 o_busy;
  logic                 o_frame_err;
  logic [3:0]           debug;

  modport master (
    input  i_rx,
    output o_data_out, o_data_DV, o_busy, o_frame_err, debug
  );

  modport slave (
    output i_rx,
    input  o_data_out, o_data_DV, o_busy, o_frame_err, debug
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM, one-cycle data-valid
// and framing-error strobes, and a BREAK state that holds off while the line stays low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to the middle of the start bit, rejecting glitches
// S_DATA  | sampling WORD_SIZE data bits mid-bit, LSB first
// S_STOP  | sampling the stop bit; good frame -> DV, low stop -> frame error
// S_BREAK | stop bit was low; wait for the line to be released
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_SIZE    = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  uart_receiver_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_DATA  = 4'd2,
    S_STOP  = 4'd3,
    S_BREAK = 4'd4
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [WORD_SIZE-1:0] r_shift;
  logic [WORD_SIZE-1:0] r_data_out;
  logic                 r_dv;
  logic                 r_ferr;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_clk_cnt_nxt;
  logic [IDX_W-1:0]     w_bit_idx_nxt;
  logic [WORD_SIZE-1:0] w_shift_nxt;
  logic [WORD_SIZE-1:0] w_data_nxt;
  logic                 w_dv_nxt;
  logic                 w_ferr_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data_out;
    w_dv_nxt      = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt   = S_START;
          // the detecting IDLE cycle counts as cycle 0 of the start bit
          w_clk_cnt_nxt = CNT_W'(1);
        end
      end
      S_START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_clk_cnt == BIT_M1) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == LAST_IDX) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_clk_cnt == BIT_M1) begin
          w_clk_cnt_nxt = '0;
          if (r_rx_s) begin
            w_data_nxt  = r_shift;
            w_dv_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_dv       <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_meta  <= bus.i_rx;
      r_rx_s     <= r_rx_meta;
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_data_out <= w_data_nxt;
      r_dv       <= w_dv_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

  assign bus.o_data_out  = r_data_out;
  assign bus.o_data_DV   = r_dv;
  assign bus.o_frame_err = r_ferr;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.debug       = r_state;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=4: reset, single frame, glitch,
// 255-byte back-to-back sweep, framing error with held-low line, and mid-frame reset.
module tb_uart_receiver;
  localparam int CPB = 4;

  logic clk;
  logic rst_n;

  uart_receiver_if #(.WORD_SIZE(8)) u_if ();

  uart_receiver #(.CLKS_PER_BIT(CPB), .WORD_SIZE(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         dv_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_q[$];
  bit         prev_dv = 0;
  bit         prev_ferr = 0;
  bit         long_pulse = 0;
  bit         both_high = 0;
  bit         saw_start = 0;
  bit         saw_busy = 0;

  always @(negedge clk) begin
    if (u_if.o_data_DV) begin
      dv_cnt++;
      rx_q.push_back(u_if.o_data_out);
      if (prev_dv) long_pulse = 1;
    end
    if (u_if.o_frame_err) begin
      ferr_cnt++;
      if (prev_ferr) long_pulse = 1;
    end
    if (u_if.o_data_DV && u_if.o_frame_err) both_high = 1;
    if (u_if.debug == 4'd1) saw_start = 1;
    if (u_if.o_busy) saw_busy = 1;
    prev_dv   = u_if.o_data_DV;
    prev_ferr = u_if.o_frame_err;
  end

  task automatic drive_bit(input logic v);
    u_if.i_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle_cycles(input int n);
    u_if.i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    u_if.i_rx = 1'b1;
    repeat (2) begin
      @(negedge clk);
      u_if.i_rx = ~u_if.i_rx;
    end
    checks++;
    if (u_if.debug !== 4'd0) begin errors++; $display("FAIL reset_debug actual=%0d required=0", u_if.debug); end
    checks++;
    if ({u_if.o_data_out, u_if.o_data_DV, u_if.o_busy, u_if.o_frame_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs data=%h dv=%b busy=%b ferr=%b required all 0",
               u_if.o_data_out, u_if.o_data_DV, u_if.o_busy, u_if.o_frame_err);
    end
    u_if.i_rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(6);
  endtask

  task automatic test_single;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = ferr_cnt;
    saw_busy = 0;
    rx_q.delete();
    send_frame(8'hA5, 1'b1);
    idle_cycles(4 * CPB);
    checks++;
    if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL single_dv_count actual=%0d required=1", dv_cnt - dv0); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      errors++; $display("FAIL single_byte actual_size=%0d required=A5", rx_q.size());
    end
    checks++;
    if (u_if.o_data_out !== 8'hA5) begin errors++; $display("FAIL single_data_out actual=%h required=a5", u_if.o_data_out); end
    checks++;
    if (ferr_cnt != fe0) begin errors++; $display("FAIL single_ferr actual=%0d required=0", ferr_cnt - fe0); end
    checks++;
    if (!saw_busy || u_if.o_busy !== 1'b0) begin
      errors++; $display("FAIL single_busy saw_busy=%b busy_after=%b required 1/0", saw_busy, u_if.o_busy);
    end
  endtask

  task automatic test_glitch;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = ferr_cnt;
    saw_start = 0;
    u_if.i_rx = 1'b0;
    @(negedge clk);
    idle_cycles(12);
    checks++;
    if (!saw_start) begin errors++; $display("FAIL glitch_start_seen actual=0 required=1"); end
    checks++;
    if (u_if.debug !== 4'd0) begin errors++; $display("FAIL glitch_debug actual=%0d required=0", u_if.debug); end
    checks++;
    if (dv_cnt != dv0 || ferr_cnt != fe0) begin
      errors++; $display("FAIL glitch_strobes dv=%0d ferr=%0d required 0/0", dv_cnt - dv0, ferr_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back;
    int dv0, fe0, bad;
    logic [7:0] exp_b;
    dv0 = dv_cnt; fe0 = ferr_cnt;
    rx_q.delete();
    for (int i = 0; i < 255; i++) send_frame(8'(i), 1'b1);
    idle_cycles(4 * CPB);
    checks++;
    if (dv_cnt - dv0 != 255) begin errors++; $display("FAIL sweep_dv_count actual=%0d required=255", dv_cnt - dv0); end
    checks++;
    if (ferr_cnt != fe0) begin errors++; $display("FAIL sweep_ferr actual=%0d required=0", ferr_cnt - fe0); end
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < 255; i++) begin
      exp_b = 8'(i);
      checks++;
      if (rx_q[i] !== exp_b) begin
        errors++;
        if (bad < 5) $display("FAIL sweep_byte[%0d] actual=%h required=%h", i, rx_q[i], exp_b);
        bad++;
      end
    end
  endtask

  task automatic test_frame_error;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (u_if.debug !== 4'd4) begin errors++; $display("FAIL ferr_break_state actual=%0d required=4", u_if.debug); end
    checks++;
    if (ferr_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses actual=%0d required=1", ferr_cnt - fe0); end
    checks++;
    if (dv_cnt != dv0) begin errors++; $display("FAIL ferr_no_dv actual=%0d required=0", dv_cnt - dv0); end
    checks++;
    if (u_if.o_data_out !== 8'hFE) begin errors++; $display("FAIL ferr_data_hold actual=%h required=fe", u_if.o_data_out); end
    idle_cycles(8);
    checks++;
    if (u_if.debug !== 4'd0) begin errors++; $display("FAIL ferr_release actual=%0d required=0", u_if.debug); end
    rx_q.delete();
    send_frame(8'h5A, 1'b1);
    idle_cycles(4 * CPB);
    checks++;
    if (rx_q.size() != 1 || u_if.o_data_out !== 8'h5A) begin
      errors++; $display("FAIL ferr_recover actual=%h count=%0d required=5a/1", u_if.o_data_out, rx_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    u_if.i_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (u_if.debug !== 4'd0 || u_if.o_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_state debug=%0d busy=%b required 0/0", u_if.debug, u_if.o_busy);
    end
    checks++;
    if (u_if.o_data_out !== 8'h00) begin errors++; $display("FAIL midrst_data actual=%h required=00", u_if.o_data_out); end
    rst_n = 1'b1;
    idle_cycles(20);
    checks++;
    if (dv_cnt != dv0 || ferr_cnt != fe0) begin
      errors++; $display("FAIL midrst_strobes dv=%0d ferr=%0d required 0/0", dv_cnt - dv0, ferr_cnt - fe0);
    end
    rx_q.delete();
    send_frame(8'h81, 1'b1);
    idle_cycles(4 * CPB);
    checks++;
    if (rx_q.size() != 1 || u_if.o_data_out !== 8'h81) begin
      errors++; $display("FAIL midrst_recover actual=%h count=%0d required=81/1", u_if.o_data_out, rx_q.size());
    end
  endtask

  task automatic test_strobe_shape;
    checks++;
    if (long_pulse) begin errors++; $display("FAIL strobe_width actual=multi-cycle required=one cycle"); end
    checks++;
    if (both_high) begin errors++; $display("FAIL strobe_exclusive actual=both high required=never"); end
  endtask

  initial begin
    u_if.i_rx = 1'b1;
    rst_n = 1'b0;
    test_reset;
    test_single;
    test_glitch;
    test_back_to_back;
    test_frame_error;
    test_reset_mid_frame;
    test_strobe_shape;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
